// File: rtl/vga_sync_gen_pkg.sv
// vga_timing_pkg: default 640x480@60 timing, counter width, derived totals.
// Also the registered output bundle type and a sync-level helper.
package vga_timing_pkg;

  localparam int CNT_W = 11;
  localparam int MAX_TOTAL = 2047;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D = 16;
  localparam int H_SYNC_D = 96;
  localparam int H_BP_D = 48;

  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D = 10;
  localparam int V_SYNC_D = 2;
  localparam int V_BP_D = 33;

  localparam int H_TOTAL_D =
    H_ACTIVE_D + H_FP_D
    + H_SYNC_D + H_BP_D;

  localparam int V_TOTAL_D =
    V_ACTIVE_D + V_FP_D
    + V_SYNC_D + V_BP_D;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic frame_start;
    logic video_on;
    logic h_sinc;
    logic v_sinc;
    cnt_t count_v;
    cnt_t count_h;
  } vga_out_t;

  // Maps "inside the sync window" to the pin level.
  // off is the inactive level (1 for active-low syncs).
  function automatic logic sync_level(
    input logic active,
    input logic off
  );
    return active ^ off;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: timing outputs of the sync generator.
// master drives h_sinc/v_sinc/countH/countV/video_on/frame_start.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic h_sinc;
  logic v_sinc;
  cnt_t countH;
  cnt_t countV;
  logic video_on;
  logic frame_start;

  modport master (
    output h_sinc,
    output v_sinc,
    output countH,
    output countV,
    output video_on,
    output frame_start
  );

  modport slave (
    input h_sinc,
    input v_sinc,
    input countH,
    input countV,
    input video_on,
    input frame_start
  );

endinterface

// File: rtl/vga_sync_gen_axis_counter.sv
// vga_axis_counter: wrap-at-LIMIT counter with enable.
// Ports: clk, reset (sync, high), en; nxt = value after this edge,
// wrap = en at LIMIT-1, win_nxt = nxt inside [WIN_LO, WIN_HI].
// Reset loads LIMIT-1 so the first enabled edge produces 0.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int LIMIT = H_TOTAL_D,
  parameter int WIN_LO = H_ACTIVE_D + H_FP_D,
  parameter int WIN_HI = H_ACTIVE_D + H_FP_D
                       + H_SYNC_D - 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output cnt_t nxt,
  output logic wrap,
  output logic win_nxt
);

  localparam cnt_t LAST = cnt_t'(LIMIT - 1);
  localparam cnt_t LO = cnt_t'(WIN_LO);
  localparam cnt_t HI = cnt_t'(WIN_HI);

  cnt_t cnt;
  logic last;
  logic step;

  assign last = (cnt == LAST);
  assign wrap = en && last;
  assign step = en && !last;

  always_comb begin
    nxt = cnt;
    unique case (1'b1)
      wrap: nxt = '0;
      step: nxt = cnt + cnt_t'(1);
      default: ;
    endcase
  end

  // Decoding the next value lets the parent register the
  // window flag on the same edge as the count: no skew.
  assign win_nxt = (nxt >= LO)
                && (nxt <= HI);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= LAST;
    end else begin
      cnt <= nxt;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA h/v sync, pixel position, video_on and frame_start.
// Ports: clk, reset (sync, active-high), vga (vga_sync_gen_if.master).
// Macro PIXEL_DIV2_EN: pixel tick every second clk via a toggle flop;
// undefined: every clk is a pixel tick.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP = V_BP_D,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic reset,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_LO = H_ACTIVE + H_FP;
  localparam int H_SYNC_HI = H_SYNC_LO + H_SYNC - 1;
  localparam int V_SYNC_LO = V_ACTIVE + V_FP;
  localparam int V_SYNC_HI = V_SYNC_LO + V_SYNC - 1;

  localparam cnt_t H_ACT_C = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT_C = cnt_t'(V_ACTIVE);

  localparam logic SYNC_OFF =
    (SYNC_ACTIVE_LOW != 0);

  logic tick;

`ifdef PIXEL_DIV2_EN
  logic div_q;

  // Reads 1 on the first clk after reset, so the
  // first tick lands on the second clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= 1'b0;
    end else begin
      div_q <= ~div_q;
    end
  end

  assign tick = div_q;
`else
  assign tick = 1'b1;
`endif

  cnt_t h_nxt;
  cnt_t v_nxt;
  logic h_wrap;
  logic v_wrap;
  logic h_win;
  logic v_win;

  vga_axis_counter #(
    .LIMIT (H_TOTAL),
    .WIN_LO(H_SYNC_LO),
    .WIN_HI(H_SYNC_HI)
  ) u_h (
    .clk    (clk),
    .reset  (reset),
    .en     (tick),
    .nxt    (h_nxt),
    .wrap   (h_wrap),
    .win_nxt(h_win)
  );

  // The line counter only moves on the tick
  // where the column counter wraps.
  vga_axis_counter #(
    .LIMIT (V_TOTAL),
    .WIN_LO(V_SYNC_LO),
    .WIN_HI(V_SYNC_HI)
  ) u_v (
    .clk    (clk),
    .reset  (reset),
    .en     (h_wrap),
    .nxt    (v_nxt),
    .wrap   (v_wrap),
    .win_nxt(v_win)
  );

  vga_out_t pix_nxt;
  vga_out_t out_q;

  always_comb begin
    pix_nxt = '0;
    pix_nxt.count_h = h_nxt;
    pix_nxt.count_v = v_nxt;
    pix_nxt.h_sinc =
      sync_level(h_win, SYNC_OFF);
    pix_nxt.v_sinc =
      sync_level(v_win, SYNC_OFF);
    pix_nxt.video_on =
      (h_nxt < H_ACT_C)
      && (v_nxt < V_ACT_C);
    // Both axes wrapping means (0,0) loads now;
    // also true on the first tick after reset.
    pix_nxt.frame_start = h_wrap && v_wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      out_q.h_sinc <= SYNC_OFF;
      out_q.v_sinc <= SYNC_OFF;
    end else if (tick) begin
      out_q <= pix_nxt;
    end else begin
      out_q.frame_start <= 1'b0;
    end
  end

  assign vga.countH = out_q.count_h;
  assign vga.countV = out_q.count_v;
  assign vga.h_sinc = out_q.h_sinc;
  assign vga.v_sinc = out_q.v_sinc;
  assign vga.video_on = out_q.video_on;
  assign vga.frame_start = out_q.frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: default-timing line checks on one DUT and a
// scoreboarded small-timing (15x8, active-high sync) DUT.
module tb_vga_sync_gen;

`ifdef PIXEL_DIV2_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  // Small DUT: H 8+2+3+2=15, V 4+1+2+1=8.
  localparam int HT = 15;
  localparam int VT = 8;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clk = ~clk;

  vga_sync_gen_if ifa ();
  vga_sync_gen_if ifb ();

  vga_sync_gen u_a (
    .clk  (clk),
    .reset(rst_a),
    .vga  (ifa)
  );

  vga_sync_gen #(
    .H_ACTIVE(8),
    .H_FP(2),
    .H_SYNC(3),
    .H_BP(2),
    .V_ACTIVE(4),
    .V_FP(1),
    .V_SYNC(2),
    .V_BP(1),
    .SYNC_ACTIVE_LOW(0)
  ) u_b (
    .clk  (clk),
    .reset(rst_b),
    .vga  (ifb)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(
    input string nm,
    input int act,
    input int exp
  );
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  // Scoreboard for the small DUT.
  // Vector: {fs, video, hs, vs, v[10:0], h[10:0]}.
  logic [25:0] exp_q[$];
  int fs_log[$];
  int cyc = 0;

  int mh = 0;
  int mv = 0;
  int nclk = 0;
  bit armed = 1'b1;
  bit mfs = 1'b0;

  task automatic model_update(input logic r);
    bit tk;
    mfs = 1'b0;
    if (r) begin
      armed = 1'b1;
      nclk = 0;
    end else begin
      nclk++;
      tk = (nclk % DIV) == 0;
      if (tk) begin
        if (armed) begin
          armed = 1'b0;
          mh = 0;
          mv = 0;
        end else begin
          mh++;
          if (mh == HT) begin
            mh = 0;
            mv++;
            if (mv == VT) mv = 0;
          end
        end
        mfs = (mh == 0) && (mv == 0);
      end
    end
  endtask

  function automatic logic [25:0] exp_vec();
    logic hs;
    logic vs;
    logic vid;
    logic [10:0] h11;
    logic [10:0] v11;
    if (armed) return 26'd0;
    hs = (mh >= 10) && (mh <= 12);
    vs = (mv >= 5) && (mv <= 6);
    vid = (mh < 8) && (mv < 4);
    h11 = 11'(mh);
    v11 = 11'(mv);
    return {mfs, vid, hs, vs, v11, h11};
  endfunction

  task automatic step_b(input logic r);
    @(negedge clk);
    rst_b = r;
    @(posedge clk);
    model_update(r);
    exp_q.push_back(exp_vec());
  endtask

  always @(negedge clk) begin
    logic [25:0] e;
    logic [25:0] a;
    cyc++;
    if (ifb.frame_start) fs_log.push_back(cyc);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {ifb.frame_start, ifb.video_on,
           ifb.h_sinc, ifb.v_sinc,
           ifb.countV, ifb.countH};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL sb_b: got %h want %h (h%0d v%0d)",
                 a, e, a[10:0], a[21:11]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int hcnt;
    int hfirst;
    int hlast;
    int vcnt;
    int fcnt;
    int seq_err;
    int guard;

    repeat (3) @(negedge clk);
    chk("a_rst_countH", int'(ifa.countH), 0);
    chk("a_rst_countV", int'(ifa.countV), 0);
    chk("a_rst_hsync", int'(ifa.h_sinc), 1);
    chk("a_rst_vsync", int'(ifa.v_sinc), 1);
    chk("a_rst_video", int'(ifa.video_on), 0);
    chk("a_rst_fs", int'(ifa.frame_start), 0);

    // One full default line, sampled on tick edges.
    rst_a = 1'b0;
    repeat (DIV) @(posedge clk);
    #1;
    chk("a_first_fs", int'(ifa.frame_start), 1);
    chk("a_first_video", int'(ifa.video_on), 1);
    chk("a_first_vsync", int'(ifa.v_sinc), 1);
    hcnt = 0;
    hfirst = -1;
    hlast = -1;
    vcnt = 0;
    fcnt = 0;
    seq_err = 0;
    for (int i = 0; i < 800; i++) begin
      if (int'(ifa.countH) != i) seq_err++;
      if (ifa.countV != 11'd0) seq_err++;
      if (!ifa.h_sinc) begin
        hcnt++;
        if (hfirst < 0) hfirst = i;
        hlast = i;
      end
      if (ifa.video_on) vcnt++;
      if (ifa.frame_start) fcnt++;
      repeat (DIV) @(posedge clk);
      #1;
    end
    chk("a_col_seq_err", seq_err, 0);
    chk("a_hsync_ticks", hcnt, 96);
    chk("a_hsync_first", hfirst, 656);
    chk("a_hsync_last", hlast, 751);
    chk("a_video_ticks", vcnt, 640);
    chk("a_fs_ticks", fcnt, 1);
    chk("a_wrap_countH", int'(ifa.countH), 0);
    chk("a_wrap_countV", int'(ifa.countV), 1);
    chk("a_wrap_fs", int'(ifa.frame_start), 0);
    rst_a = 1'b1;

    // Small DUT: reset, two+ frames incl. (14,7)->(0,0).
    step_b(1'b1);
    step_b(1'b1);
    for (int i = 0; i < 260 * DIV; i++)
      step_b(1'b0);

    // Mid-frame reset at (6,2) for one clk.
    guard = 0;
    while (!(mh == 6 && mv == 2 && !armed)
           && guard < 400) begin
      step_b(1'b0);
      guard++;
    end
    chk("b_mid_pos_reached", int'(guard < 400), 1);
    step_b(1'b1);
    fs_log.delete();

    // Frame period after release.
    for (int i = 0; i < 360 * DIV + 4; i++)
      step_b(1'b0);
    @(negedge clk);
    #1;
    chk("b_fs_count", fs_log.size(), 4);
    if (fs_log.size() == 4) begin
      for (int i = 1; i < 4; i++)
        chk("b_fs_period",
            fs_log[i] - fs_log[i-1],
            120 * DIV);
    end
    chk("b_sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The block SHALL have one clock and one reset; the reset SHALL be synchronous and active-high.
REQ-002 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-003 Parameter H_FP, 16, horizontal front porch in pixels.
REQ-004 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-005 Parameter H_BP, 48, horizontal back porch in pixels.
REQ-006 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-007 Parameter V_FP, 10, vertical front porch in lines.
REQ-008 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-009 Parameter V_BP, 33, vertical back porch in lines.
REQ-010 Parameter SYNC_ACTIVE_LOW, 1, sync polarity: 1 means active level 0, 0 means active level 1.
REQ-011 Port clk, input, 1, system clock.
REQ-012 Port reset, input, 1, synchronous active-high reset.
REQ-013 Port h_sinc, output, 1, horizontal sync at the configured polarity.
REQ-014 Port v_sinc, output, 1, vertical sync at the configured polarity.
REQ-015 Port countH, output, 11, current pixel column, 0..H_TOTAL-1.
REQ-016 Port countV, output, 11, current line, 0..V_TOTAL-1.
REQ-017 Port video_on, output, 1, high iff countH<H_ACTIVE and countV<V_ACTIVE.
REQ-018 Port frame_start, output, 1, one-clk pulse when (0,0) is loaded.

Function
REQ-019 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP (default 800), and V_TOTAL SHALL be the corresponding vertical sum (default 525); both totals SHALL be at most 2047.
REQ-020 On each pixel tick, countH SHALL increment; at H_TOTAL-1 it SHALL wrap to 0, and in that same tick countV SHALL increment.
REQ-021 countV SHALL wrap from V_TOTAL-1 to 0 only on the tick where countH also wraps.
REQ-022 h_sinc SHALL be at its active level iff countH is within [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751 by default.
REQ-023 v_sinc SHALL be at its active level iff countV is within [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491 by default.
REQ-024 All outputs SHALL be registered and SHALL update on the same clk edge as the counters, with zero skew between countH/countV and the syncs and video_on.
REQ-025 frame_start SHALL be high for exactly one clk on the edge where (countV,countH) becomes (0,0), in every divider mode.
REQ-026 Between pixel ticks, all outputs except frame_start SHALL hold their values.

Reset
REQ-027 While reset is high, the internal counters SHALL load (H_TOTAL-1, V_TOTAL-1), countH and countV SHALL read 0, h_sinc and v_sinc SHALL be inactive, video_on SHALL be 0, frame_start SHALL be 0, and the divider flop SHALL be 0.
REQ-028 The first pixel tick after reset releases SHALL produce (0,0) with video_on=1 and frame_start=1.
REQ-029 Reset asserted mid-frame SHALL take effect on the next clk edge, with no partial line completed.

Configuration
REQ-030 Macro PIXEL_DIV2_EN defined: an internal toggle flop SHALL generate a pixel tick on every second clk (the toggle reads 1 on the first clk after reset, so the first tick falls on the second clk after reset).
REQ-031 Macro PIXEL_DIV2_EN undefined: every clk SHALL be a pixel tick.

Structure
REQ-032 Package vga_timing_pkg SHALL hold the default 640x480 timing constants, the counter width constant (11), and the derived totals.
REQ-033 Sub-module vga_axis_counter (a wrap-at-limit counter with enable, a wrap output, and a window-decode output) SHALL be instantiated twice, once horizontal and once vertical.

Verification
REQ-034 Release reset, run 800 ticks -> h_sinc low for exactly 96 consecutive ticks at countH 656..751, and video_on high for exactly 640 ticks.
REQ-035 Run one full frame -> v_sinc low for 1600 ticks (lines 490..491), and frame_start pulses once every 420000 clk.
REQ-036 At (799,524) apply one tick -> next outputs are (0,0), video_on=1, frame_start=1, and v_sinc inactive.
REQ-037 Assert reset at (300,100) for 1 clk -> next outputs are 0/0, syncs inactive, video_on=0; the first tick after release gives (0,0).
REQ-038 With PIXEL_DIV2_EN defined -> countH advances every 2 clk, the frame period is 840000 clk, and frame_start stays 1 clk wide.
REQ-039 With SYNC_ACTIVE_LOW=0 -> h_sinc and v_sinc are high only in the windows of REQ-022 and REQ-023, and low during reset.
